// File: rtl/pwm_light_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pwm_light_sequencer                                          |
// | Description : Brightness level sequencer for the PWM light path. Debounced |
// |               button pulses step the level in MANUAL mode; AUTO mode       |
// |               breathes the level up and down on a free-running step timer. |
// |               The level reaches the brightness MUX only on PWM period      |
// |               boundaries, so the duty cycle never changes mid-period.      |
// | Option      : `define IDLE_OFF_EN to turn the light off after              |
// |               TIMEOUT_STEPS step intervals without a button in MANUAL.     |
// | Ports       : i_clk            system clock                                |
// |               i_reset          asynchronous reset, active low             |
// |               i_btn_up         1-cycle pulse, brighter                     |
// |               i_btn_down       1-cycle pulse, dimmer                       |
// |               i_btn_mode       1-cycle pulse, toggle MANUAL/AUTO           |
// |               i_pwm_period_end 1-cycle pulse on PWM counter wrap           |
// |               o_light_state    level select to MUX, 0..NUM_LEVELS-1        |
// |               o_mode           0=MANUAL 1=FADE_UP 2=FADE_DOWN              |
// |               o_step           1-cycle pulse when the step timer expires   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module pwm_light_sequencer #(
  parameter int NUM_LEVELS    = 5,
  parameter int STEP_TICKS    = 10_000_000,
  parameter int TIMEOUT_STEPS = 60
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic       i_btn_mode,
  input  logic       i_pwm_period_end,
  output logic [2:0] o_light_state,
  output logic [1:0] o_mode,
  output logic       o_step
);

  localparam int              c_tw       = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [c_tw-1:0] c_tmr_max  = c_tw'(STEP_TICKS - 1);
  localparam logic [2:0]      c_lvl_max  = 3'(NUM_LEVELS - 1);

  typedef enum logic [1:0] {
    ST_MANUAL    = 2'd0,
    ST_FADE_UP   = 2'd1,
    ST_FADE_DOWN = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_lvl;
  logic [2:0]      w_lvl_fsm;
  logic [2:0]      w_lvl_nxt;
  logic [c_tw-1:0] r_timer;
  logic [c_tw-1:0] w_timer_nxt;
  logic            w_step;
  logic            w_up;
  logic            w_down;

  // Simultaneous up and down cancel out.
  assign w_up   = i_btn_up & ~i_btn_down;
  assign w_down = i_btn_down & ~i_btn_up;
  assign w_step = (r_timer == c_tmr_max);

  assign o_step = w_step;
  assign o_mode = r_state;

  // --------------------------------------------------------------------------
  // Next-state / pending level. Mode pulses take priority over everything,
  // including a coincident timer step, which is then dropped.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_lvl_fsm   = r_lvl;
    case (r_state)
      ST_MANUAL: begin
        if (i_btn_mode) begin
          w_state_nxt = (r_lvl < c_lvl_max) ? ST_FADE_UP : ST_FADE_DOWN;
        end else if (w_up) begin
          if (r_lvl < c_lvl_max) w_lvl_fsm = r_lvl + 3'd1;
        end else if (w_down) begin
          if (r_lvl != 3'd0) w_lvl_fsm = r_lvl - 3'd1;
        end
      end
      ST_FADE_UP: begin
        if (i_btn_mode) begin
          w_state_nxt = ST_MANUAL;
        end else if (w_step) begin
          if (r_lvl < c_lvl_max) w_lvl_fsm = r_lvl + 3'd1;
          // Turn around on the same edge the top level is reached.
          if (r_lvl >= c_lvl_max - 3'd1) w_state_nxt = ST_FADE_DOWN;
        end
      end
      ST_FADE_DOWN: begin
        if (i_btn_mode) begin
          w_state_nxt = ST_MANUAL;
        end else if (w_step) begin
          if (r_lvl != 3'd0) w_lvl_fsm = r_lvl - 3'd1;
          if (r_lvl <= 3'd1) w_state_nxt = ST_FADE_UP;
        end
      end
      default: begin
        w_state_nxt = ST_MANUAL;
      end
    endcase
  end

  // Step timer free-runs in every state; any change of mode restarts it so a
  // fresh fade always gets a full step interval.
  always_comb begin
    w_timer_nxt = r_timer + 1'b1;
    if ((w_state_nxt != r_state) || w_step) w_timer_nxt = '0;
  end

`ifdef IDLE_OFF_EN
  localparam int              c_iw       = $clog2(TIMEOUT_STEPS + 1);
  localparam logic [c_iw-1:0] c_idle_max = c_iw'(TIMEOUT_STEPS);

  logic [c_iw-1:0] r_idle;
  logic [c_iw-1:0] w_idle_nxt;
  logic            w_idle_fire;
  logic            w_btn_any;

  assign w_btn_any = i_btn_up | i_btn_down | i_btn_mode;

  // Idle counter only advances in MANUAL; it saturates at the timeout value
  // so the off-forcing happens once and then waits for the next button.
  always_comb begin
    w_idle_nxt  = r_idle;
    w_idle_fire = 1'b0;
    if ((r_state != ST_MANUAL) || w_btn_any) begin
      w_idle_nxt = '0;
    end else if (w_step && (r_idle != c_idle_max)) begin
      w_idle_nxt  = r_idle + 1'b1;
      w_idle_fire = (r_idle == c_idle_max - 1'b1);
    end
  end

  assign w_lvl_nxt = w_idle_fire ? 3'd0 : w_lvl_fsm;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_idle <= '0;
    end else begin
      r_idle <= w_idle_nxt;
    end
  end
`else
  assign w_lvl_nxt = w_lvl_fsm;
`endif

  // --------------------------------------------------------------------------
  // State, pending level and timer registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_MANUAL;
      r_lvl   <= 3'd0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lvl   <= w_lvl_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // Output shadow: samples the pre-edge pending level at each period wrap, so
  // a level change on the wrap edge itself lands one period later.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_light_state <= 3'd0;
    end else if (i_pwm_period_end) begin
      o_light_state <= r_lvl;
    end
  end

endmodule
`default_nettype wire
